recv_shadow: RTL and testbench
==============================

# recv_shadow

Receiving end of the shadow-ray path. Accepts shadow-ray intersection results returning from scene intersection (one per shadow ray issued by `send_shadow`), classifies each ray as lit or occluded by comparing the hit parameter against the light segment, and buffers the verdicts for the pixel-colour calculation stage. Sits between the sint result return and `pcalc`, with valid/stall handshakes on both sides.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: output buffer entries; power of two, ≥4.
- `EPS_BITS`, 32'h3A83_126F: IEEE-754 single bits of the self-intersection epsilon (0.001).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sint_to_recvshadow_valid`  in  1  result valid.
- `sint_to_recvshadow_data`  in  42  {rayID[8:0], hit[0], t_int[31:0]}; t_int is IEEE single, parametric along the unnormalised direction `light − p_int`.
- `sint_to_recvshadow_stall`  out  1  upstream must hold data while high.
- `recvshadow_to_pcalc_valid`  out  1  verdict available.
- `recvshadow_to_pcalc_data`  out  10  {rayID[8:0], lit[0]}.
- `recvshadow_to_pcalc_stall`  in  1  downstream back-pressure.
- `lit_count`, `shadow_count`  out  16 each  present only with `RECV_SHADOW_STATS_EN`.

## Operation
- Accept: input transfer occurs on a rising edge where `valid && !stall`. Valid while stall is high is not accepted and not counted.
- Stage 1 (S1): accepted {rayID, hit, t_int} registered with `s1_valid`.
- Classification (combinational on S1): occluded iff all hold:
  - `hit == 1`;
  - sign bit of t_int is 0;
  - exponent ≠ 8'hFF (NaN/Inf never occlude);
  - `t_int[30:0] >= EPS_BITS[30:0]` (unsigned compare, valid for non-negative floats);
  - `t_int[30:0] < 31'h3F80_0000` (t < 1.0, i.e. occluder lies before the light).
  - `lit = !occluded`. +0.0, −0.0, denormals below EPS: lit.
- Stage 2: if `s1_valid`, {rayID, lit} pushed into the FIFO on the next edge. S1 never stalls; space is guaranteed by the stall rule.
- FIFO: circular, read/write pointers of log2(FIFO_DEPTH) bits that wrap naturally, count of log2(FIFO_DEPTH)+1 bits. Head is presented combinationally: `recvshadow_to_pcalc_valid = (count != 0)`. Pop on edge where `valid && !recvshadow_to_pcalc_stall`.
- Stall rule: `sint_to_recvshadow_stall = (count + s1_valid) >= FIFO_DEPTH − 1`, combinational from registers only (no path from input valid or downstream stall).
- Simultaneous push and pop: count unchanged, both pointers advance; legal at any count including full and empty+S1.
- Order: verdicts leave in acceptance order; rayID passes through unchanged.
- Reset: `s1_valid`=0, pointers=0, count=0, so `recvshadow_to_pcalc_valid`=0, `sint_to_recvshadow_stall`=0, data output = 0; stats counters = 0. Reset mid-operation discards S1 and all FIFO contents with no output handshake.

## Timing
- Latency: input accepted at edge N → pushed at edge N+1 → `recvshadow_to_pcalc_valid` high in the cycle after edge N+1 (2 edges) when FIFO was empty.
- Throughput: one result per cycle while downstream does not stall.
- With downstream stalled permanently from empty: exactly FIFO_DEPTH−1 results are accepted before stall holds; no overflow, no loss.
- Stall deasserts the cycle after the pop that brings `count + s1_valid` below FIFO_DEPTH−1.
- Output data is stable while valid is high and stall is high.

## Configuration
- `RECV_SHADOW_STATS_EN` defined: `lit_count`/`shadow_count` ports exist; on each FIFO push the matching counter increments by 1, saturating at 16'hFFFF; cleared by `rst`.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles; drive rayID 0, hit=1, t=0.5 (32'h3F00_0000) → output {0, lit=0} exactly 2 edges after acceptance.
- Boundaries: rayID 1 t=1.0 → lit=1; rayID 2 t=0.0009 → lit=1; rayID 3 t=0.001 (EPS_BITS) → lit=0; rayID 4 hit=0 t=0.5 → lit=1; rayID 5 t=−0.5 → lit=1; rayID 6 t=NaN 32'h7FC0_0000 → lit=1.
- Back-pressure: hold `recvshadow_to_pcalc_stall`=1, stream 20 results → exactly 7 accepted (FIFO_DEPTH=8), stall=1; release → 7 outputs in order, then remaining 13 flow, none lost or duplicated.
- Full-rate simultaneous push/pop: random downstream stall at 50% over 512 rays (rayID 0..511) → output rayID sequence identical to input, count never exceeds FIFO_DEPTH.
- Reset mid-stream with 5 entries buffered → valid drops the cycle after rst edge; subsequent ray rayID 9 emerges alone with correct verdict.
- With `RECV_SHADOW_STATS_EN`: 3 occluded + 4 lit rays → shadow_count=3, lit_count=4; after `rst` both 0.

Source files
------------

// File: rtl/recv_shadow.sv
// recv_shadow: classifies returning shadow-ray hits as lit/occluded and buffers verdicts for pcalc.
// Optional per-verdict statistics counters are built when RECV_SHADOW_STATS_EN is defined.
module recv_shadow #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] EPS_BITS   = 32'h3A83_126F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sint_to_recvshadow_valid,
  input  logic [41:0] sint_to_recvshadow_data,
  output logic        sint_to_recvshadow_stall,
  output logic        recvshadow_to_pcalc_valid,
  output logic [9:0]  recvshadow_to_pcalc_data,
  input  logic        recvshadow_to_pcalc_stall
`ifdef RECV_SHADOW_STATS_EN
  ,
  output logic [15:0] lit_count,
  output logic [15:0] shadow_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW+1:0] STALL_LVL = (AW+2)'(FIFO_DEPTH - 1);
  localparam logic [30:0]   ONE_MAG   = 31'h3F80_0000;

  // Stage 1 registers
  logic        r_s1_valid;
  logic [8:0]  r_s1_id;
  logic        r_s1_hit;
  logic [31:0] r_s1_t;

  // Verdict buffer
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_occluded;
  logic          w_lit;
  logic [AW+1:0] w_level;

  // Stall looks only at registered occupancy so it never combinationally depends on valid.
  assign w_level  = {1'b0, r_count} + {{(AW+1){1'b0}}, r_s1_valid};
  assign sint_to_recvshadow_stall = (w_level >= STALL_LVL);
  assign w_accept = sint_to_recvshadow_valid && !sint_to_recvshadow_stall;

  // Non-negative floats order like unsigned integers, so magnitude compares are bit compares.
  assign w_occluded = r_s1_hit
                   && !r_s1_t[31]
                   && (r_s1_t[30:23] != 8'hFF)
                   && (r_s1_t[30:0] >= EPS_BITS[30:0])
                   && (r_s1_t[30:0] < ONE_MAG);
  assign w_lit = !w_occluded;

  assign recvshadow_to_pcalc_valid = (r_count != '0);
  assign recvshadow_to_pcalc_data  = recvshadow_to_pcalc_valid ? r_mem[r_rd_ptr] : 10'd0;

  assign w_push = r_s1_valid;
  assign w_pop  = recvshadow_to_pcalc_valid && !recvshadow_to_pcalc_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_hit   <= 1'b0;
      r_s1_t     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_id  <= sint_to_recvshadow_data[41:33];
        r_s1_hit <= sint_to_recvshadow_data[32];
        r_s1_t   <= sint_to_recvshadow_data[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_s1_id, w_lit};
    end
  end

  // Pointers are exactly AW bits wide, so they wrap at FIFO_DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef RECV_SHADOW_STATS_EN
  logic [15:0] r_lit_count;
  logic [15:0] r_shadow_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lit_count    <= '0;
      r_shadow_count <= '0;
    end else if (w_push) begin
      if (w_lit && (r_lit_count != 16'hFFFF))
        r_lit_count <= r_lit_count + 16'd1;
      if (!w_lit && (r_shadow_count != 16'hFFFF))
        r_shadow_count <= r_shadow_count + 16'd1;
    end
  end

  assign lit_count    = r_lit_count;
  assign shadow_count = r_shadow_count;
`endif

endmodule

// File: tb/tb_recv_shadow.sv
// Randomized self-checking bench for recv_shadow against a real-arithmetic verdict model.
// Define RECV_SHADOW_STATS_EN to also exercise the statistics counters.
module tb_recv_shadow;

  localparam int          DEPTH = 8;
  localparam logic [31:0] EPS   = 32'h3A83_126F;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [41:0] in_data;
  logic        in_stall;
  logic        out_valid;
  logic [9:0]  out_data;
  logic        ds_stall;
`ifdef RECV_SHADOW_STATS_EN
  logic [15:0] lit_cnt;
  logic [15:0] sh_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  recv_shadow #(.FIFO_DEPTH(DEPTH), .EPS_BITS(EPS)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .sint_to_recvshadow_valid  (in_valid),
    .sint_to_recvshadow_data   (in_data),
    .sint_to_recvshadow_stall  (in_stall),
    .recvshadow_to_pcalc_valid (out_valid),
    .recvshadow_to_pcalc_data  (out_data),
    .recvshadow_to_pcalc_stall (ds_stall)
`ifdef RECV_SHADOW_STATS_EN
    ,
    .lit_count                 (lit_cnt),
    .shadow_count              (sh_cnt)
`endif
  );

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_value(input logic [31:0] b);
    int  e = int'(b[30:23]);
    real m = real'(b[22:0]) / 8388608.0;
    real v;
    if (e == 0) v = m * pow2(-126);
    else        v = (1.0 + m) * pow2(e - 127);
    return b[31] ? -v : v;
  endfunction

  // Occluded only for a real hit whose distance lies in [eps, 1.0) along the light segment.
  function automatic bit ref_lit(input bit hit, input logic [31:0] t);
    real v;
    if (!hit) return 1'b1;
    if (t[30:23] == 8'hFF) return 1'b1;
    v = fp_value(t);
    return !((v >= fp_value(EPS)) && (v < 1.0));
  endfunction

  function automatic logic [9:0] ref_out(input logic [41:0] r);
    logic [8:0] id = r[41:33];
    return {id, ref_lit(r[32], r[31:0])};
  endfunction

  function automatic logic [31:0] rand_t();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0: t = $urandom;
      1: t = {1'b0, 8'($urandom_range(117, 126)), 23'($urandom)};
      2: t = {1'b0, 8'($urandom_range(116, 117)), 23'($urandom)};
      3: t = {1'b1, 8'($urandom_range(100, 130)), 23'($urandom)};
      4: t = {1'b0, 8'hFF, 23'($urandom_range(0, 3))};
      default: t = {1'b0, 8'($urandom_range(127, 130)), 23'($urandom)};
    endcase
    return t;
  endfunction

  // ---------------- cycle driver (no checking) ----------------
  task automatic step(input bit rs, input bit v, input logic [41:0] d, input bit ds,
                      output bit acc, output bit pop, output logic [9:0] pd);
    @(negedge clk);
    rst      = rs;
    in_valid = v;
    in_data  = d;
    ds_stall = ds;
    #1;
    acc = v && !in_stall && !rs;
    pop = out_valid && !ds && !rs;
    pd  = out_data;
  endtask

  task automatic run_traffic(input logic [41:0] rays[$], input int stall_pct, input int gap_pct,
                             input int max_cycles, output logic [9:0] got[$],
                             output int max_inflight, output bit timeout);
    int idx = 0;
    int inflight = 0;
    int cyc = 0;
    bit a, p, v, ds;
    logic [9:0] pd;
    got = {};
    max_inflight = 0;
    timeout = 1'b0;
    while (got.size() < rays.size()) begin
      if (cyc >= max_cycles) begin
        timeout = 1'b1;
        break;
      end
      v  = (idx < rays.size()) && (int'($urandom_range(0, 99)) >= gap_pct);
      ds = int'($urandom_range(0, 99)) < stall_pct;
      step(1'b0, v, (idx < rays.size()) ? rays[idx] : 42'd0, ds, a, p, pd);
      if (a) begin idx++; inflight++; end
      if (p) begin got.push_back(pd); inflight--; end
      if (inflight > max_inflight) max_inflight = inflight;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit a, p;
    logic [9:0] pd;
    logic [41:0] r0;
    step(1'b1, 1'b0, 42'd0, 1'b0, a, p, pd);
    step(1'b1, 1'b0, 42'd0, 1'b0, a, p, pd);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 42'd0, 1'b0, a, p, pd);
      total++;
      if ({out_valid, in_stall, out_data} !== 12'h000)
        $display("FAIL reset_idle cycle %0d: got v=%b s=%b d=%h required all 0", i, out_valid, in_stall, out_data);
      else passed++;
    end
    r0 = {9'd0, 1'b1, 32'h3F00_0000};
    step(1'b0, 1'b1, r0, 1'b0, a, p, pd);
    total++;
    if (a !== 1'b1) $display("FAIL first_accept: got %b required 1", a);
    else passed++;
    step(1'b0, 1'b0, 42'd0, 1'b0, a, p, pd);
    total++;
    if (out_valid !== 1'b0) $display("FAIL latency_edge1: valid got %b required 0", out_valid);
    else passed++;
    step(1'b0, 1'b0, 42'd0, 1'b0, a, p, pd);
    total++;
    if ({out_valid, out_data} !== {1'b1, ref_out(r0)})
      $display("FAIL latency_edge2: got v=%b d=%h required v=1 d=%h", out_valid, out_data, ref_out(r0));
    else passed++;
    step(1'b0, 1'b0, 42'd0, 1'b0, a, p, pd);
    total++;
    if (out_valid !== 1'b0) $display("FAIL after_pop: valid got %b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_boundaries();
    logic [41:0] rays[$];
    logic [9:0]  got[$];
    int mi;
    bit to;
    rays.push_back({9'd1, 1'b1, 32'h3F80_0000});
    rays.push_back({9'd2, 1'b1, 32'h3A6B_EDFA});
    rays.push_back({9'd3, 1'b1, EPS});
    rays.push_back({9'd4, 1'b0, 32'h3F00_0000});
    rays.push_back({9'd5, 1'b1, 32'hBF00_0000});
    rays.push_back({9'd6, 1'b1, 32'h7FC0_0000});
    run_traffic(rays, 0, 0, 100, got, mi, to);
    total++;
    if (to || got.size() != rays.size())
      $display("FAIL boundary_count: got %0d outputs required %0d", got.size(), rays.size());
    else passed++;
    for (int i = 0; i < got.size() && i < rays.size(); i++) begin
      total++;
      if (got[i] !== ref_out(rays[i]))
        $display("FAIL boundary_ray%0d: got %h required %h", i + 1, got[i], ref_out(rays[i]));
      else passed++;
    end
  endtask

  task automatic test_back_pressure();
    logic [41:0] rays[$];
    logic [9:0]  got[$];
    logic [9:0]  held;
    bit a, p, seen, unstable;
    logic [9:0] pd;
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < 20; i++) rays.push_back({9'(100 + i), 1'($urandom), rand_t()});
    seen = 1'b0;
    unstable = 1'b0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, idx < 20, (idx < 20) ? rays[idx] : 42'd0, 1'b1, a, p, pd);
      if (a) idx++;
      if (out_valid) begin
        if (!seen) begin held = out_data; seen = 1'b1; end
        else if (out_data !== held) unstable = 1'b1;
      end
    end
    total++;
    if (idx != DEPTH - 1) $display("FAIL bp_accepted: got %0d required %0d", idx, DEPTH - 1);
    else passed++;
    total++;
    if (in_stall !== 1'b1) $display("FAIL bp_stall: got %b required 1", in_stall);
    else passed++;
    total++;
    if (!seen || unstable) $display("FAIL bp_head_stable: seen=%b unstable=%b required seen=1 unstable=0", seen, unstable);
    else passed++;
    while (got.size() < 20 && cyc < 200) begin
      step(1'b0, idx < 20, (idx < 20) ? rays[idx] : 42'd0, 1'b0, a, p, pd);
      if (a) idx++;
      if (p) got.push_back(pd);
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (got.size() != 20) $display("FAIL bp_drain_count: got %0d required 20", got.size());
    else passed++;
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== ref_out(rays[i]))
        $display("FAIL bp_order%0d: got %h required %h", i, got[i], ref_out(rays[i]));
      else passed++;
    end
  endtask

  task automatic test_random_stream();
    logic [41:0] rays[$];
    logic [9:0]  got[$];
    int mi, bad;
    bit to;
    for (int i = 0; i < 512; i++) rays.push_back({9'(i), 1'($urandom_range(0, 3) != 0), rand_t()});
    run_traffic(rays, 50, 15, 20000, got, mi, to);
    total++;
    if (to || got.size() != 512) $display("FAIL rand_count: got %0d required 512", got.size());
    else passed++;
    total++;
    if (mi > DEPTH - 1) $display("FAIL rand_occupancy: got %0d required <= %0d", mi, DEPTH - 1);
    else passed++;
    bad = 0;
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== ref_out(rays[i])) begin
        bad++;
        if (bad <= 10) $display("FAIL rand_ray%0d: got %h required %h", i, got[i], ref_out(rays[i]));
      end else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [41:0] rays[$];
    logic [9:0]  got[$];
    bit a, p, to;
    logic [9:0] pd;
    int n = 0;
    int extra = 0;
    int mi;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step(1'b0, 1'b1, {9'(200 + n), 1'b1, 32'h3F00_0000}, 1'b1, a, p, pd);
      if (a) n++;
    end
    step(1'b0, 1'b0, 42'd0, 1'b1, a, p, pd);
    step(1'b0, 1'b0, 42'd0, 1'b1, a, p, pd);
    total++;
    if (n != 5 || out_valid !== 1'b1) $display("FAIL mid_prefill: got n=%0d v=%b required 5 and 1", n, out_valid);
    else passed++;
    step(1'b1, 1'b0, 42'd0, 1'b1, a, p, pd);
    step(1'b0, 1'b0, 42'd0, 1'b0, a, p, pd);
    total++;
    if ({out_valid, in_stall, out_data} !== 12'h000)
      $display("FAIL mid_reset_clear: got v=%b s=%b d=%h required all 0", out_valid, in_stall, out_data);
    else passed++;
    rays.push_back({9'd9, 1'b1, 32'h3E80_0000});
    run_traffic(rays, 0, 0, 50, got, mi, to);
    total++;
    if (to || got.size() != 1 || got[0] !== ref_out(rays[0]))
      $display("FAIL mid_ray9: got n=%0d d=%h required 1 and %h", got.size(), (got.size() > 0) ? got[0] : 10'h0, ref_out(rays[0]));
    else passed++;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 42'd0, 1'b0, a, p, pd);
      if (p) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL mid_no_stale: got %0d extra outputs required 0", extra);
    else passed++;
  endtask

`ifdef RECV_SHADOW_STATS_EN
  task automatic test_stats();
    logic [41:0] rays[$];
    logic [9:0]  got[$];
    bit a, p, to;
    logic [9:0] pd;
    int mi, nl, ns;
    step(1'b1, 1'b0, 42'd0, 1'b0, a, p, pd);
    for (int i = 0; i < 3; i++) rays.push_back({9'(300 + i), 1'b1, 32'h3F00_0000});
    for (int i = 0; i < 4; i++) rays.push_back({9'(310 + i), 1'b0, 32'h3F00_0000});
    nl = 0;
    ns = 0;
    foreach (rays[i]) if (ref_lit(rays[i][32], rays[i][31:0])) nl++; else ns++;
    run_traffic(rays, 0, 0, 100, got, mi, to);
    total++;
    if (to || sh_cnt !== 16'(ns) || lit_cnt !== 16'(nl))
      $display("FAIL stats_counts: got shadow=%0d lit=%0d required %0d %0d", sh_cnt, lit_cnt, ns, nl);
    else passed++;
    step(1'b1, 1'b0, 42'd0, 1'b0, a, p, pd);
    step(1'b0, 1'b0, 42'd0, 1'b0, a, p, pd);
    total++;
    if ({sh_cnt, lit_cnt} !== 32'd0)
      $display("FAIL stats_reset: got shadow=%0d lit=%0d required 0 0", sh_cnt, lit_cnt);
    else passed++;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    ds_stall = 1'b0;
    test_reset();
    test_boundaries();
    test_back_pressure();
    test_random_stream();
    test_reset_midstream();
`ifdef RECV_SHADOW_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
